// File: rtl/div_16bit_seq_pkg.sv
// Shared definitions for the 16-bit sequential restoring divider:
// FSM state encoding and iteration constants.
package div_16bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_STEPS = 16;
  localparam logic [3:0] STEP_INIT = 4'(DIV_STEPS - 1);
  localparam logic [15:0] ZERO_DIV_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit adder/subtractor: mode=1 inverts b, so with cin=1 it computes a-b
// and cout=1 means the subtraction did not borrow.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        mode,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] b_eff;
  logic [16:0] total;

  // Operand conditioning and carry-propagating sum
  always_comb begin
    if (mode) begin
      b_eff = ~b;
    end else begin
      b_eff = b;
    end
    total = {1'b0, a} + {1'b0, b_eff} + {16'd0, cin};
  end

  assign sum  = total[15:0];
  assign cout = total[16];

endmodule

// File: rtl/div_16bit_seq.sv
// Unsigned 16/16 restoring divider, one quotient bit per cycle MSB first.
// Results are held until the next completion; done pulses as DONE exits.
module div_16bit_seq
  import div_16bit_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  state_t      state;
  logic [15:0] dvs;
  logic [15:0] rem;
  logic [15:0] q;
  logic [3:0]  count;

  logic [15:0] shifted_rem;
  logic [15:0] trial;
  logic        no_borrow;
  logic        accept;
  logic [15:0] next_rem;
  logic [15:0] next_q;

  // The dividend bit entering the remainder comes from the top of q.
  assign shifted_rem = {rem[14:0], q[15]};

  adder_16bit u_sub (
    .a    (shifted_rem),
    .b    (dvs),
    .cin  (1'b1),
    .mode (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // Restoring step: the bit shifted out of rem counts as an implicit 17th bit
  always_comb begin
    accept = rem[15] | no_borrow;
    if (accept) begin
      next_rem = trial;
    end else begin
      next_rem = shifted_rem;
    end
    next_q = {q[14:0], accept};
  end

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvs         <= 16'd0;
      rem         <= 16'd0;
      q           <= 16'd0;
      count       <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'd0;
      remainder   <= 16'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor != 16'd0) begin
              dvs   <= divisor;
              q     <= dividend;
              rem   <= 16'd0;
              count <= STEP_INIT;
              state <= RUN;
            end else begin
              quotient    <= ZERO_DIV_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          rem   <= next_rem;
          q     <= next_q;
          count <= count - 4'd1;
          if (count == 4'd0) begin
            quotient    <= next_q;
            remainder   <= next_rem;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16bit_seq.sv
// Self-checking bench for div_16bit_seq: vector table, corner sequences and
// randomized back-to-back operations checked through an expected-result queue.
module tb_div_16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          poke;
  } vec_t;

  exp_t exp_queue[$];
  vec_t vecs[10];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_done = 0;
  int n_done = 0;
  bit check_spacing = 1'b0;

  div_16bit_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (done) begin
      n_done = n_done + 1;
      n_cmp = n_cmp + 1;
      if (exp_queue.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_done at cycle %0d: q=%h r=%h z=%b with nothing expected",
                 cyc, quotient, remainder, div_by_zero);
      end else begin
        e = exp_queue.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
          n_fail = n_fail + 1;
          $display("FAIL result: got q=%h r=%h z=%b, expected q=%h r=%h z=%b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
      end
      if (check_spacing && last_done != 0) begin
        n_cmp = n_cmp + 1;
        if (cyc - last_done != 18) begin
          n_fail = n_fail + 1;
          $display("FAIL done_spacing: got %0d cycles, expected 18", cyc - last_done);
        end
      end
      last_done = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Caller is at a negedge. Launches one division, optionally pokes start at
  // cycle poke_k, and returns at the negedge where done is seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ez, input int poke_k);
    exp_t e;
    int lat;
    bit seen;
    bit busy_ok;
    lat = (b == 16'd0) ? 2 : 18;
    seen = 1'b0;
    busy_ok = 1'b1;
    e.q = eq;
    e.r = er;
    e.z = ez;
    exp_queue.push_back(e);
    dividend = a;
    divisor = b;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
      end
      if (k == poke_k) begin
        start = 1'b1;
        dividend = 16'd1;
        divisor = 16'd1;
      end
      if (k == poke_k + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        check("latency", 32'(k), 32'(lat));
        check("busy_during_op", {31'd0, busy_ok}, 32'd1);
        break;
      end
      if (k < lat && !busy) begin
        busy_ok = 1'b0;
      end
    end
    if (!seen) begin
      n_cmp = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL done_timeout: no done within 40 cycles for %h / %h", a, b);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int done_before;

    vecs[0] = '{16'd7,     16'd2,     16'd3,     16'd1,     1'b0, 0};
    vecs[1] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'd0,     1'b0, 0};
    vecs[2] = '{16'h8000,  16'hFFFF,  16'd0,     16'h8000,  1'b0, 0};
    vecs[3] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1, 0};
    vecs[4] = '{16'd9,     16'd3,     16'd3,     16'd0,     1'b0, 0};
    vecs[5] = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 5};
    vecs[6] = '{16'd12345, 16'd256,   16'd48,    16'd57,    1'b0, 17};
    vecs[7] = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0, 0};
    vecs[8] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0, 0};
    vecs[9] = '{16'd1000,  16'd3,     16'd333,   16'd1,     1'b0, 0};

    // Reset with start held high: start must be ignored
    rst = 1'b1;
    start = 1'b1;
    dividend = 16'd7;
    divisor = 16'd2;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", {16'd0, quotient}, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    // Table-driven vectors, run back to back
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].poke);
    end
    repeat (25) @(negedge clk);
    check("queue_drained", 32'(exp_queue.size()), 32'd0);
    check("idle_after_table", {31'd0, busy}, 32'd0);

    // Abort mid-run with reset (start also high during reset)
    done_before = n_done;
    dividend = 16'd1000;
    divisor = 16'd3;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {16'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(n_done - done_before), 32'd0);
    do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 0);

    // Randomized back-to-back operations with spacing checks
    check_spacing = 1'b1;
    last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rb = 16'($urandom_range(1, 255));
      end else begin
        rb = 16'($urandom);
      end
      if (rb == 16'd0) rb = 16'd1;
      do_op(ra, rb, ra / rb, ra % rb, 1'b0, 0);
    end
    check_spacing = 1'b0;
    repeat (25) @(negedge clk);
    check("final_queue_drained", 32'(exp_queue.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
